csi_tx_packet_builder: RTL

//  - CSI-2 transmit packetizer, 2-lane (16-bit word: [7:0]=lane0=earlier byte, [15:8]=lane1).
//  - Takes frame/line commands plus payload stream; emits SYNC word, header+ECC, payload, CRC-16.
//  - Feeds the TX serializer; loops back into csi_rx byte/word aligners and packet handler in sim.
//  - ECC via csi_rx_hdr_ecc instance (24-bit in, 8-bit out, combinational).

---
 rtl/csi_tx_packet_builder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/csi_tx_packet_builder.sv
// CSI-2 two-lane transmit packetizer: SYNC word, packet header with ECC, payload and CRC-16.
// Each lane word carries lane0 (the earlier byte) in [7:0] and lane1 in [15:8].

module csi_rx_hdr_ecc (
  input  logic [23:0] data,
  output logic [7:0]  ecc
);

  // Six-bit Hamming parity over the 24 header bits; the top two ECC bits are always zero.
  assign ecc[0] = data[0] ^ data[1] ^ data[2] ^ data[4] ^ data[5] ^ data[7] ^ data[10] ^
                  data[11] ^ data[13] ^ data[16] ^ data[20] ^ data[21] ^ data[22] ^ data[23];
  assign ecc[1] = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6] ^ data[8] ^ data[10] ^
                  data[12] ^ data[14] ^ data[17] ^ data[20] ^ data[21] ^ data[22] ^ data[23];
  assign ecc[2] = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6] ^ data[9] ^ data[11] ^
                  data[12] ^ data[15] ^ data[18] ^ data[20] ^ data[21] ^ data[22];
  assign ecc[3] = data[1] ^ data[2] ^ data[3] ^ data[7] ^ data[8] ^ data[9] ^ data[13] ^
                  data[14] ^ data[15] ^ data[19] ^ data[20] ^ data[21] ^ data[23];
  assign ecc[4] = data[4] ^ data[5] ^ data[6] ^ data[7] ^ data[8] ^ data[9] ^ data[16] ^
                  data[17] ^ data[18] ^ data[19] ^ data[20] ^ data[22] ^ data[23];
  assign ecc[5] = data[10] ^ data[11] ^ data[12] ^ data[13] ^ data[14] ^ data[15] ^ data[16] ^
                  data[17] ^ data[18] ^ data[19] ^ data[21] ^ data[22] ^ data[23];
  assign ecc[7:6] = 2'b00;

endmodule

module csi_tx_packet_builder #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_WC     = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_dt,
  input  logic [15:0] cmd_wc,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        err_underrun,
  output logic        err_wc
);

  localparam logic [15:0] MAX_WC_W = 16'(MAX_WC);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR0, S_HDR1, S_PAYLOAD, S_CRC, S_TRAIL
  } state_t;

  state_t         state;
  logic [15:0]    tx_reg;
  logic [15:0]    wc_q;
  logic [7:0]     di_q;
  logic [15:0]    crc;
  logic [15:0]    byte_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [15:0]    wc_fix;
  logic           wc_bad;
  logic [7:0]     ecc;
  logic [15:0]    payload_word;
  logic [15:0]    crc_next;
  logic           is_short;
  logic           pay_last;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  csi_rx_hdr_ecc u_ecc (
    .data ({wc_q, di_q}),
    .ecc  (ecc)
  );

  // Odd counts lose bit 0 and oversized counts clamp; either correction is flagged.
  always_comb begin
    wc_fix = {cmd_wc[15:1], 1'b0};
    wc_bad = cmd_wc[0];
    if (cmd_wc > MAX_WC_W) begin
      wc_fix = MAX_WC_W;
      wc_bad = 1'b1;
    end
  end

  // A missing payload word is replaced by zeros so the HS burst never pauses.
  assign payload_word = pix_valid ? pix_data : 16'h0000;
  assign crc_next     = crc16_byte(crc16_byte(crc, payload_word[7:0]), payload_word[15:8]);
  assign is_short     = (di_q[5:0] < 6'h10);
  assign pay_last     = (byte_cnt == wc_q - 16'd2);

  assign cmd_ready = (state == S_IDLE) & enable;
  assign pix_ready = (state == S_PAYLOAD) & enable;
  assign busy      = (state != S_IDLE);
  assign tx_valid  = (state == S_SYNC) | (state == S_HDR0) | (state == S_HDR1) |
                     (state == S_PAYLOAD) | (state == S_CRC);
  assign tx_data   = (state == S_PAYLOAD) ? payload_word : tx_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tx_reg       <= 16'h0000;
      wc_q         <= 16'h0000;
      di_q         <= 8'h00;
      crc          <= 16'hFFFF;
      byte_cnt     <= 16'h0000;
      gap_cnt      <= '0;
      err_underrun <= 1'b0;
      err_wc       <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            wc_q   <= wc_fix;
            di_q   <= {2'b00, cmd_dt};
            tx_reg <= 16'hB8B8;
            state  <= S_SYNC;
            if (wc_bad) err_wc <= 1'b1;
          end
        end
        S_SYNC: begin
          tx_reg <= {wc_q[7:0], di_q};
          state  <= S_HDR0;
        end
        S_HDR0: begin
          tx_reg <= {ecc, wc_q[15:8]};
          state  <= S_HDR1;
        end
        S_HDR1: begin
          crc      <= 16'hFFFF;
          byte_cnt <= 16'h0000;
          gap_cnt  <= '0;
          if (is_short) begin
            tx_reg <= 16'h0000;
            state  <= S_TRAIL;
          end else if (wc_q == 16'h0000) begin
            tx_reg <= 16'hFFFF;
            state  <= S_CRC;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          crc <= crc_next;
          if (!pix_valid) err_underrun <= 1'b1;
          if (pay_last) begin
            tx_reg <= crc_next;
            state  <= S_CRC;
          end else begin
            byte_cnt <= byte_cnt + 16'd2;
          end
        end
        S_CRC: begin
          tx_reg  <= 16'h0000;
          gap_cnt <= '0;
          state   <= S_TRAIL;
        end
        S_TRAIL: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
